// File: rtl/md_unit_if.sv
// Request/result bundle between the main controller and the multiply/divide unit.
// The unit side uses the slave modport.
interface md_unit_if;
  logic        start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDOp, A, B, input busy, done, HI, LO);
  modport slave  (input start, MDOp, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional madd/maddu/msub/msubu support is enabled with the MD_MADD_EN macro.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam int unsigned CW = 4;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi_q, lo_q;
  logic          busy_q, done_q;

  logic          div_op_c, run_op_c;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   b_nz, mag_a, mag_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [63:0]   res_c;
  logic          res_we_c;

  // Request decode: which codes start a multi-cycle operation
  assign div_op_c = (md.MDOp == OP_DIV) || (md.MDOp == OP_DIVU);
`ifdef MD_MADD_EN
  assign run_op_c = (md.MDOp == OP_MULT) || (md.MDOp == OP_MULTU) || div_op_c ||
                    ((md.MDOp >= OP_MADD) && (md.MDOp <= OP_MSUBU));
`else
  assign run_op_c = (md.MDOp == OP_MULT) || (md.MDOp == OP_MULTU) || div_op_c;
`endif

  // Products from the latched operands
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Division on magnitudes so the most-negative dividend needs no special case;
  // a zero divisor is replaced by one because its result is discarded anyway.
  assign b_nz  = (b_q == 32'd0) ? 32'd1 : b_q;
  assign mag_a = a_q[31]  ? 32'(-a_q)  : a_q;
  assign mag_b = b_nz[31] ? 32'(-b_nz) : b_nz;
  assign q_mag = mag_a / mag_b;
  assign r_mag = mag_a % mag_b;
  assign q_s   = (a_q[31] ^ b_nz[31]) ? 32'(-q_mag) : q_mag;
  assign r_s   = a_q[31] ? 32'(-r_mag) : r_mag;
  assign q_u   = a_q / b_nz;
  assign r_u   = a_q % b_nz;

  // Result selection for the final RUN edge
  always_comb begin
    res_c    = {hi_q, lo_q};
    res_we_c = 1'b1;
    case (op_q)
      OP_MULT:  res_c = prod_s;
      OP_MULTU: res_c = prod_u;
      OP_DIV: begin
        res_c    = {r_s, q_s};
        res_we_c = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res_c    = {r_u, q_u};
        res_we_c = (b_q != 32'd0);
      end
`ifdef MD_MADD_EN
      OP_MADD:  res_c = {hi_q, lo_q} + prod_s;
      OP_MADDU: res_c = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res_c = {hi_q, lo_q} - prod_s;
      OP_MSUBU: res_c = {hi_q, lo_q} - prod_u;
`endif
      default:  res_we_c = 1'b0;
    endcase
  end

  // Control FSM, counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (md.start) begin
            if (run_op_c) begin
              op_q   <= md.MDOp;
              a_q    <= md.A;
              b_q    <= md.B;
              cnt    <= div_op_c ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              busy_q <= 1'b1;
              state  <= RUN;
            end else if (md.MDOp == OP_MTHI) begin
              hi_q <= md.A;
            end else if (md.MDOp == OP_MTLO) begin
              lo_q <= md.A;
            end
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (res_we_c) begin
              hi_q <= res_c[63:32];
              lo_q <= res_c[31:0];
            end
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core. Sits in the EX stage beside the ALU and holds the architectural HI/LO registers.
- Responds to operation requests issued by the main controller, and reports a busy status back to the stall controller.
- The stall controller holds mult/div/mfhi/mflo/mthi/mtlo in ID while busy is high or a start is in EX.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (and madd-family when enabled); legal range 1..15.
- DIV_CYCLES, 10, number of busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request qualifier; MDOp, A and B are sampled only when start=1.
- MDOp  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 reserved.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse; new HI/LO are visible this cycle.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: when reset=0 at a clk edge, HI=0, LO=0, busy=0, done=0, counter=0, FSM=IDLE. Reset taken mid-operation aborts the operation; no HI/LO write occurs.
- FSM states are IDLE and RUN.
- IDLE with start=1 and MDOp in 1..4 (or 7..10 when enabled):
  - Latch A, B and MDOp.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - busy=1 from the next cycle.
- IDLE with start=1 and MDOp=5 (mthi) or 6 (mtlo): HI (or LO) is written with A at that edge. No busy, no done.
- RUN:
  - The counter decrements every cycle.
  - When counter=1, the result is written to HI/LO at that edge, FSM returns to IDLE, and done=1 in the following cycle only.
  - Timing: start sampled in cycle T; busy=1 in cycles T+1..T+N; HI/LO new and busy=0, done=1 in cycle T+N+1.
- start=1 while busy=1 is ignored entirely (operands not sampled, HI/LO untouched). The controller must never issue it.
- start=1 with MDOp=0 or a reserved code: no effect.
- A new start is accepted in the same cycle done=1 (back-to-back issue).
- Arithmetic:
  - mult: signed 32x32 to 64-bit product; HI=upper, LO=lower.
  - multu: unsigned 32x32 to 64-bit product; HI=upper, LO=lower.
  - div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (B=0): HI and LO unchanged; busy and done timing unchanged.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- HI/LO outputs are registered and change only at the write edges above. The old values remain readable while busy.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - MDOp 7/8 (madd/maddu): {HI,LO} += signed/unsigned A*B, modulo 2^64.
  - MDOp 9/10 (msub/msubu): {HI,LO} -= signed/unsigned A*B, modulo 2^64.
  - These use MULT_CYCLES. The {HI,LO} value used is the one present when start is sampled.
- Undefined: codes 7..10 are treated as reserved (no effect, busy stays 0).

Test Plan:
- Reset: reset=0 for one edge after arbitrary activity -> HI=0, LO=0, busy=0, done=0. Repeat with reset asserted at the 3rd busy cycle of a div -> HI/LO stay 0, busy=0 next cycle.
- Signed mult: start with MDOp=1, A=0xFFFFFFFE (-2), B=3 in cycle T -> busy=1 for T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, done=1 for exactly one cycle.
- Unsigned mult: MDOp=2, A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- Divide:
  - MDOp=3, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - MDOp=4 (divu), same operands -> LO=0x7FFFFFFC, HI=0x00000001.
  - B=0 -> HI/LO keep prior values, done still pulses at T+11.
- Move and ignore rules:
  - mthi A=0x12345678 -> HI=0x12345678 the next cycle, busy stays 0.
  - start with mtlo issued during busy -> ignored, LO unchanged.
  - Back-to-back: new mult issued in the done cycle -> accepted; busy=1 in the following cycle.
- With MD_MADD_EN: HI:LO=0x00000000_FFFFFFFF, maddu A=1, B=1 -> HI=0x00000001, LO=0x00000000. Without the macro, the same request leaves HI/LO unchanged and busy=0.
